pixel_fetch_sequencer: RTL and testbench

Upstream control stage for parallel_pixel_fetch. It walks an image region in raster order: one 64-bit memory word (8 pixels) per fetch, rows outer, words inner. For each word it drives base_addr, row_offset, col_offset and a one-cycle fetch_start, then waits for fetch_done before issuing the next fetch. It is gated by PE-array readiness and tags each fetch with row/column position and first/last flags for the downstream windowing logic.

---
 rtl/pixel_fetch_sequencer_pkg.sv | 14 +
 rtl/pixel_fetch_sequencer_raster_counter.sv | 82 ++++++++
 rtl/pixel_fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_pixel_fetch_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_sequencer_pkg.sv
// Shared types and constants for the pixel fetch sequencer.
package pixel_fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_FINISH    = 2'd3
   } state_t;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
   localparam int unsigned PIXELS_PER_WORD    = 8;

endpackage

// File: rtl/pixel_fetch_sequencer_raster_counter.sv
// Raster position tracker: row/col counters, row offset accumulator and position flags.
module raster_counter
   import pixel_fetch_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DIM_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load,
   input  logic                  step,
   input  logic [DIM_WIDTH-1:0]  cfg_words_per_row,
   input  logic [DIM_WIDTH-1:0]  cfg_num_rows,
   output logic [DIM_WIDTH-1:0]  cur_row,
   output logic [DIM_WIDTH-1:0]  cur_col,
   output logic [ADDR_WIDTH-1:0] row_offset,
   output logic [ADDR_WIDTH-1:0] col_offset,
   output logic                  first_col,
   output logic                  last_col,
   output logic                  last_fetch
);

   logic [DIM_WIDTH-1:0]  wpr_q;
   logic [DIM_WIDTH-1:0]  rows_q;
   logic [DIM_WIDTH-1:0]  nxt_row;
   logic [DIM_WIDTH-1:0]  nxt_col;
   logic [DIM_WIDTH-1:0]  nxt_wpr;
   logic [DIM_WIDTH-1:0]  nxt_rows;
   logic [ADDR_WIDTH-1:0] nxt_off;
   logic                  nxt_last_col;

   // Next position: load restarts at the origin, step walks the raster.
   always_comb begin
      nxt_row  = cur_row;
      nxt_col  = cur_col;
      nxt_off  = row_offset;
      nxt_wpr  = wpr_q;
      nxt_rows = rows_q;
      if (load) begin
         nxt_wpr  = cfg_words_per_row;
         nxt_rows = cfg_num_rows;
         nxt_row  = '0;
         nxt_col  = '0;
         nxt_off  = '0;
      end else if (step) begin
         if (last_col) begin
            nxt_col = '0;
            nxt_row = cur_row + DIM_WIDTH'(1);
            nxt_off = row_offset + ADDR_WIDTH'(wpr_q);
         end else begin
            nxt_col = cur_col + DIM_WIDTH'(1);
         end
      end
      nxt_last_col = (nxt_col == nxt_wpr - DIM_WIDTH'(1));
   end

   // Flags are registered from the next position so they line up with the counters.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wpr_q      <= '0;
         rows_q     <= '0;
         cur_row    <= '0;
         cur_col    <= '0;
         row_offset <= '0;
         first_col  <= 1'b0;
         last_col   <= 1'b0;
         last_fetch <= 1'b0;
      end else if (load || step) begin
         wpr_q      <= nxt_wpr;
         rows_q     <= nxt_rows;
         cur_row    <= nxt_row;
         cur_col    <= nxt_col;
         row_offset <= nxt_off;
         first_col  <= (nxt_col == '0);
         last_col   <= nxt_last_col;
         last_fetch <= nxt_last_col && (nxt_row == nxt_rows - DIM_WIDTH'(1));
      end
   end

   assign col_offset = ADDR_WIDTH'(cur_col);

endmodule

// File: rtl/pixel_fetch_sequencer.sv
// Raster-order fetch sequencer: issues one word fetch at a time, gated by PE readiness.
module pixel_fetch_sequencer
   import pixel_fetch_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned DIM_WIDTH      = 8,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [DIM_WIDTH-1:0]  cfg_words_per_row,
   input  logic [DIM_WIDTH-1:0]  cfg_num_rows,
   input  logic                  pe_ready,
   output logic                  fetch_en,
   output logic                  fetch_start,
   output logic [ADDR_WIDTH-1:0] base_addr,
   output logic [ADDR_WIDTH-1:0] row_offset,
   output logic [ADDR_WIDTH-1:0] col_offset,
   input  logic                  fetch_done,
   output logic [DIM_WIDTH-1:0]  cur_row,
   output logic [DIM_WIDTH-1:0]  cur_col,
   output logic                  first_col,
   output logic                  last_col,
   output logic                  last_fetch,
   output logic                  busy,
   output logic                  seq_done,
   output logic                  timeout_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state;
   logic [TW-1:0] tcnt;
   logic          load_c;
   logic          step_c;
   logic          zero_dim_c;

   assign load_c     = (state == S_IDLE) && start && !abort;
   assign step_c     = (state == S_WAIT_DONE) && !abort && fetch_done && !last_fetch;
   assign zero_dim_c = (cfg_words_per_row == '0) || (cfg_num_rows == '0);

   raster_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DIM_WIDTH  (DIM_WIDTH)
   ) u_raster (
      .clk               (clk),
      .rstn              (rstn),
      .load              (load_c),
      .step              (step_c),
      .cfg_words_per_row (cfg_words_per_row),
      .cfg_num_rows      (cfg_num_rows),
      .cur_row           (cur_row),
      .cur_col           (cur_col),
      .row_offset        (row_offset),
      .col_offset        (col_offset),
      .first_col         (first_col),
      .last_col          (last_col),
      .last_fetch        (last_fetch)
   );

   // Sequencer FSM; abort outranks fetch_done and timeout in every busy state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= S_IDLE;
         tcnt        <= '0;
         fetch_en    <= 1'b0;
         fetch_start <= 1'b0;
         base_addr   <= '0;
         busy        <= 1'b0;
         seq_done    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         fetch_start <= 1'b0;
         seq_done    <= 1'b0;
         if (abort && state != S_IDLE) begin
            state    <= S_IDLE;
            fetch_en <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (load_c) begin
                     base_addr   <= cfg_base_addr;
                     timeout_err <= 1'b0;
                     fetch_en    <= 1'b1;
                     busy        <= 1'b1;
                     state       <= zero_dim_c ? S_FINISH : S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (pe_ready) begin
                     fetch_start <= 1'b1;
                     tcnt        <= '0;
                     state       <= S_WAIT_DONE;
                  end
               end
               S_WAIT_DONE: begin
                  if (fetch_done) begin
                     tcnt  <= '0;
                     state <= last_fetch ? S_FINISH : S_ISSUE;
                  end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                     timeout_err <= 1'b1;
                     fetch_en    <= 1'b0;
                     busy        <= 1'b0;
                     state       <= S_IDLE;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
               S_FINISH: begin
                  seq_done <= 1'b1;
                  fetch_en <= 1'b0;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Self-checking bench for pixel_fetch_sequencer with a fetch-order scoreboard.
module tb_pixel_fetch_sequencer;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] cfg_base_addr = '0;
   logic [DW-1:0] cfg_words_per_row = '0;
   logic [DW-1:0] cfg_num_rows = '0;
   logic          pe_ready = 1'b0;
   logic          fetch_done = 1'b0;
   logic          fetch_en, fetch_start, first_col, last_col, last_fetch;
   logic          busy, seq_done, timeout_err;
   logic [AW-1:0] base_addr, row_offset, col_offset;
   logic [DW-1:0] cur_row, cur_col;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW-1:0] roff;
      logic [AW-1:0] coff;
      logic [DW-1:0] row;
      logic [DW-1:0] col;
      logic          first;
      logic          lastc;
      logic          lastf;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   fetch_cnt = 0;
   int   seq_cnt = 0;
   bit   prev_fs = 1'b0;

   pixel_fetch_sequencer #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .start             (start),
      .abort             (abort),
      .cfg_base_addr     (cfg_base_addr),
      .cfg_words_per_row (cfg_words_per_row),
      .cfg_num_rows      (cfg_num_rows),
      .pe_ready          (pe_ready),
      .fetch_en          (fetch_en),
      .fetch_start       (fetch_start),
      .base_addr         (base_addr),
      .row_offset        (row_offset),
      .col_offset        (col_offset),
      .fetch_done        (fetch_done),
      .cur_row           (cur_row),
      .cur_col           (cur_col),
      .first_col         (first_col),
      .last_col          (last_col),
      .last_fetch        (last_fetch),
      .busy              (busy),
      .seq_done          (seq_done),
      .timeout_err       (timeout_err)
   );

   always #5 clk = ~clk;

   // Monitor: every fetch_start pops the scoreboard and checks position/flags.
   always @(negedge clk) begin
      if (rstn) begin
         if (fetch_start) begin
            exp_t e;
            fetch_cnt++;
            checks++;
            if (prev_fs) begin
               errors++;
               $display("FAIL fetch_start_pulse: high two cycles in a row, required one-cycle pulse");
            end
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_fetch_start: got fetch_start, required none (row_off=%h col_off=%h)",
                        row_offset, col_offset);
            end else begin
               e = sbq.pop_front();
               checks++;
               if ({base_addr, row_offset, col_offset, cur_row, cur_col, first_col, last_col, last_fetch,
                    fetch_en, busy} !==
                   {e.base, e.roff, e.coff, e.row, e.col, e.first, e.lastc, e.lastf, 1'b1, 1'b1}) begin
                  errors++;
                  $display("FAIL fetch_tag: got base=%h roff=%h coff=%h row=%0d col=%0d f/lc/lf=%b%b%b en=%b busy=%b, required base=%h roff=%h coff=%h row=%0d col=%0d f/lc/lf=%b%b%b en=1 busy=1",
                           base_addr, row_offset, col_offset, cur_row, cur_col, first_col, last_col,
                           last_fetch, fetch_en, busy, e.base, e.roff, e.coff, e.row, e.col, e.first,
                           e.lastc, e.lastf);
               end
            end
         end
         if (seq_done) seq_cnt++;
         prev_fs = fetch_start;
      end else begin
         prev_fs = 1'b0;
      end
   end

   task automatic push_seq(input logic [AW-1:0] base, input int wpr, input int rows, input int limit);
      int n = 0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < wpr; c++) begin
            exp_t e;
            if (n < limit) begin
               e.base  = base;
               e.roff  = AW'((r * wpr) % (1 << AW));
               e.coff  = AW'(c);
               e.row   = DW'(r);
               e.col   = DW'(c);
               e.first = (c == 0);
               e.lastc = (c == wpr - 1);
               e.lastf = (c == wpr - 1) && (r == rows - 1);
               sbq.push_back(e);
            end
            n++;
         end
      end
   endtask

   task automatic start_seq(input logic [AW-1:0] base, input int wpr, input int rows, input int limit);
      @(negedge clk);
      cfg_base_addr     = base;
      cfg_words_per_row = DW'(wpr);
      cfg_num_rows      = DW'(rows);
      start             = 1'b1;
      push_seq(base, wpr, rows, limit);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_fetch(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fetch_start) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL wait_fetch_start: got no fetch_start within 40 cycles, required one");
      end
   endtask

   task automatic serve(input int delay);
      bit seen;
      wait_fetch(seen);
      if (seen) begin
         repeat (delay) @(negedge clk);
         fetch_done = 1'b1;
         @(negedge clk);
         fetch_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({fetch_en, fetch_start, base_addr, row_offset, col_offset, cur_row, cur_col, first_col, last_col,
           last_fetch, busy, seq_done, timeout_err} !== 60'd0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b fs=%b busy=%b sd=%b te=%b roff=%h, required all zero",
                  fetch_en, fetch_start, busy, seq_done, timeout_err, row_offset);
      end
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, fetch_en, first_col} !== 3'b000) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b en=%b first=%b, required 000", busy, fetch_en, first_col);
      end
   endtask

   task automatic test_basic_raster();
      int f0 = fetch_cnt;
      pe_ready = 1'b1;
      start_seq(12'h100, 3, 2, 6);
      for (int i = 0; i < 6; i++) serve(4);
      @(negedge clk);
      checks++;
      if (seq_done !== 1'b1) begin
         errors++;
         $display("FAIL basic_seq_done: got %b, required 1 one cycle after last fetch_done", seq_done);
      end
      @(negedge clk);
      checks++;
      if ({seq_done, busy, fetch_en} !== 3'b000) begin
         errors++;
         $display("FAIL basic_after_done: got sd/busy/en=%b%b%b, required 000", seq_done, busy, fetch_en);
      end
      checks++;
      if (fetch_cnt - f0 != 6 || sbq.size() != 0) begin
         errors++;
         $display("FAIL basic_fetch_count: got %0d fetches (%0d pending), required 6 (0)",
                  fetch_cnt - f0, sbq.size());
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      pe_ready = 1'b0;
      start_seq(12'h0A0, 2, 1, 2);
      for (int i = 0; i < 10; i++) begin
         if ({fetch_start, busy, fetch_en, row_offset, col_offset} !== {3'b011, 24'd0}) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold: got %0d bad cycles, required 0 (fs=0 busy=1 offsets stable)", bad);
      end
      pe_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (fetch_start !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: got fetch_start=%b, required 1 the cycle after pe_ready", fetch_start);
      end
      repeat (3) @(negedge clk);
      fetch_done = 1'b1;
      @(negedge clk);
      fetch_done = 1'b0;
      serve(3);
      @(negedge clk);
      checks++;
      if (seq_done !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_done: got seq_done=%b, required 1", seq_done);
      end
   endtask

   task automatic test_zero_dim();
      int f0 = fetch_cnt;
      start_seq(12'h300, 5, 0, 0);
      checks++;
      if ({busy, seq_done} !== 2'b10) begin
         errors++;
         $display("FAIL zero_dim_busy: got busy/sd=%b%b, required 10", busy, seq_done);
      end
      @(negedge clk);
      checks++;
      if (seq_done !== 1'b1) begin
         errors++;
         $display("FAIL zero_dim_done: got seq_done=%b, required 1 two cycles after start", seq_done);
      end
      @(negedge clk);
      checks++;
      if ({busy, seq_done} !== 2'b00 || fetch_cnt != f0) begin
         errors++;
         $display("FAIL zero_dim_after: got busy/sd=%b%b fetches=%0d, required 00 and 0",
                  busy, seq_done, fetch_cnt - f0);
      end
   endtask

   task automatic test_timeout();
      bit seen;
      int s0 = seq_cnt;
      pe_ready = 1'b1;
      start_seq(12'h010, 1, 1, 1);
      wait_fetch(seen);
      repeat (15) @(negedge clk);
      checks++;
      if ({timeout_err, busy} !== 2'b01) begin
         errors++;
         $display("FAIL timeout_early: got te/busy=%b%b on 16th wait cycle, required 01", timeout_err, busy);
      end
      @(negedge clk);
      checks++;
      if ({timeout_err, busy, fetch_en} !== 3'b100 || seq_cnt != s0) begin
         errors++;
         $display("FAIL timeout_fire: got te/busy/en=%b%b%b seq_done_count=%0d, required 100 and 0",
                  timeout_err, busy, fetch_en, seq_cnt - s0);
      end
      start_seq(12'h020, 1, 1, 1);
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: got timeout_err=%b after new start, required 0", timeout_err);
      end
      serve(2);
      @(negedge clk);
      checks++;
      if (seq_done !== 1'b1) begin
         errors++;
         $display("FAIL timeout_recover: got seq_done=%b, required 1", seq_done);
      end
   endtask

   task automatic test_abort();
      bit seen;
      int f0, s0;
      pe_ready = 1'b1;
      start_seq(12'h400, 3, 2, 3);
      serve(2);
      serve(2);
      wait_fetch(seen);
      @(negedge clk);
      abort      = 1'b1;
      fetch_done = 1'b1;
      @(negedge clk);
      abort      = 1'b0;
      fetch_done = 1'b0;
      f0 = fetch_cnt;
      s0 = seq_cnt;
      checks++;
      if ({busy, fetch_en, fetch_start, seq_done} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_idle: got busy/en/fs/sd=%b%b%b%b, required 0000",
                  busy, fetch_en, fetch_start, seq_done);
      end
      checks++;
      if ({cur_row, cur_col, row_offset, col_offset} !== {8'd0, 8'd2, 12'd0, 12'd2}) begin
         errors++;
         $display("FAIL abort_hold: got row=%0d col=%0d roff=%h coff=%h, required 0 2 000 002",
                  cur_row, cur_col, row_offset, col_offset);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (fetch_cnt != f0 || seq_cnt != s0 || sbq.size() != 0) begin
         errors++;
         $display("FAIL abort_quiet: got %0d fetches %0d seq_done %0d pending, required 0 0 0",
                  fetch_cnt - f0, seq_cnt - s0, sbq.size());
      end
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_vs_start: got busy=%b, required 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      bit seen;
      int f0 = fetch_cnt;
      pe_ready = 1'b1;
      start_seq(12'h040, 2, 2, 4);
      serve(2);
      wait_fetch(seen);
      @(negedge clk);
      cfg_base_addr     = 12'hFFF;
      cfg_words_per_row = 8'd7;
      start             = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      fetch_done = 1'b1;
      @(negedge clk);
      fetch_done = 1'b0;
      serve(2);
      serve(2);
      @(negedge clk);
      checks++;
      if (seq_done !== 1'b1 || fetch_cnt - f0 != 4 || base_addr !== 12'h040) begin
         errors++;
         $display("FAIL start_while_busy: got sd=%b fetches=%0d base=%h, required 1 4 040",
                  seq_done, fetch_cnt - f0, base_addr);
      end
      start_seq(12'h200, 4, 1, 4);
      wait_fetch(seen);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if ({fetch_en, fetch_start, base_addr, row_offset, col_offset, cur_row, cur_col, first_col, last_col,
           last_fetch, busy, seq_done, timeout_err} !== 60'd0) begin
         errors++;
         $display("FAIL reset_mid: got en=%b busy=%b base=%h col=%0d first=%b, required all zero",
                  fetch_en, busy, base_addr, cur_col, first_col);
      end
      sbq.delete();
      rstn = 1'b1;
      f0 = fetch_cnt;
      repeat (6) @(negedge clk);
      checks++;
      if (fetch_cnt != f0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_quiet: got %0d fetches busy=%b, required 0 and 0", fetch_cnt - f0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic_raster();
      test_backpressure();
      test_zero_dim();
      test_timeout();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
